// File: rtl/wdt_timeout_ctrl.sv
// Two-stage watchdog timeout escalation: first unserviced timeout raises irq,
// second one issues a fixed-length system-reset request. Keyed kicks reload the timer.
module wdt_timeout_ctrl #(
    parameter int          RST_PULSE_W = 16,            // 1..255
    parameter logic [31:0] KICK_KEY    = 32'hACCE_55ED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wdtov,
    input  logic        kick_valid,
    input  logic [31:0] kick_data,
    input  logic        irq_clr,
    output logic        reload_req,
    output logic        irq,
    output logic        bad_key,
    output logic        sys_rst_req,
    output logic [1:0]  state,
    output logic [7:0]  tmo_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WARN  = 2'd2,
        S_RESET = 2'd3
    } state_e;

    // Counter is loaded with W-1 on entry so the RESET state lasts exactly W cycles.
    localparam logic [7:0] PULSE_LOAD = 8'(RST_PULSE_W - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        irq_q, irq_d;
    logic        bad_key_q, bad_key_d;
    logic        reload_q, reload_d;
    logic        sys_rst_q, sys_rst_d;
    logic        wdtov_q;

    logic        ev;
    logic        key_ok;
    logic        valid_kick;
    logic        bad_kick;
    logic        tmo_inc;

    assign ev         = en & wdtov & ~wdtov_q;
    assign key_ok     = (kick_data == KICK_KEY);
    assign valid_kick = kick_valid & key_ok;
    assign bad_kick   = kick_valid & ~key_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        bad_key_d = bad_key_q;
        reload_d  = 1'b0;
        tmo_inc   = 1'b0;

        // Clear first so that any set condition below takes priority.
        if (irq_clr) begin
            irq_d     = 1'b0;
            bad_key_d = 1'b0;
        end

        if (bad_kick && (state_q != S_RESET)) begin
            irq_d     = 1'b1;
            bad_key_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (valid_kick) begin
                    reload_d = 1'b1;
                end else if (ev) begin
                    state_d = S_WARN;
                    irq_d   = 1'b1;
                    tmo_inc = 1'b1;
                end
            end
            S_WARN: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (valid_kick) begin
                    state_d  = S_ARMED;
                    reload_d = 1'b1;
                end else if (ev) begin
                    state_d = S_RESET;
                    cnt_d   = PULSE_LOAD;
                    tmo_inc = 1'b1;
                end
            end
            S_RESET: begin
                // Kicks, events and enable changes are deliberately ignored here.
                if (cnt_q == 8'd0) begin
                    state_d = en ? S_ARMED : S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tmo_d = tmo_q;
        if (tmo_inc && (tmo_q != 8'hFF)) begin
            tmo_d = tmo_q + 8'd1;
        end

        sys_rst_d = (state_d == S_RESET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            tmo_q     <= 8'd0;
            irq_q     <= 1'b0;
            bad_key_q <= 1'b0;
            reload_q  <= 1'b0;
            sys_rst_q <= 1'b0;
            wdtov_q   <= 1'b1;   // timer reads 0 out of reset; that is not a timeout
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            irq_q     <= irq_d;
            bad_key_q <= bad_key_d;
            reload_q  <= reload_d;
            sys_rst_q <= sys_rst_d;
            wdtov_q   <= wdtov;
        end
    end

    assign reload_req  = reload_q;
    assign irq         = irq_q;
    assign bad_key     = bad_key_q;
    assign sys_rst_req = sys_rst_q;
    assign state       = state_q;
    assign tmo_count   = tmo_q;

endmodule

// File: tb/tb_wdt_timeout_ctrl.sv
// Directed bench for wdt_timeout_ctrl: escalation, service, bad key, conflicts,
// saturation and asynchronous mid-pulse reset.
module tb_wdt_timeout_ctrl;

    localparam logic [31:0] KEY = 32'hACCE_55ED;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ARMED = 2'd1;
    localparam logic [1:0]  ST_WARN  = 2'd2;
    localparam logic [1:0]  ST_RESET = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wdtov;
    logic        kick_valid;
    logic [31:0] kick_data;
    logic        irq_clr;
    logic        reload_req;
    logic        irq;
    logic        bad_key;
    logic        sys_rst_req;
    logic [1:0]  state;
    logic [7:0]  tmo_count;

    int n_vec = 0;
    int n_bad = 0;

    wdt_timeout_ctrl #(
        .RST_PULSE_W (16),
        .KICK_KEY    (KEY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wdtov       (wdtov),
        .kick_valid  (kick_valid),
        .kick_data   (kick_data),
        .irq_clr     (irq_clr),
        .reload_req  (reload_req),
        .irq         (irq),
        .bad_key     (bad_key),
        .sys_rst_req (sys_rst_req),
        .state       (state),
        .tmo_count   (tmo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_reset_exit(input string tag);
        for (int k = 0; k < 40 && state == ST_RESET; k++) tick();
        if (state == ST_RESET) chk(tag, 32'(state), 32'(ST_ARMED));
    endtask

    int pulse_cnt;

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        wdtov      = 1'b1;
        kick_valid = 1'b0;
        kick_data  = 32'h0;
        irq_clr    = 1'b0;
        #12;
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_irq", 32'(irq), 0);
        chk("rst_badkey", 32'(bad_key), 0);
        chk("rst_sysrst", 32'(sys_rst_req), 0);
        chk("rst_reload", 32'(reload_req), 0);
        chk("rst_tmo", 32'(tmo_count), 0);

        // Post-reset masking: wdtov held high is not a timeout.
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        chk("mask_state", 32'(state), 32'(ST_ARMED));
        chk("mask_irq", 32'(irq), 0);
        chk("mask_tmo", 32'(tmo_count), 0);
        tick();
        tick();
        chk("mask_irq2", 32'(irq), 0);
        wdtov = 1'b0;
        tick();

        // Escalation: two single-cycle overflow pulses 100 cycles apart.
        wdtov = 1'b1;
        tick();
        wdtov = 1'b0;
        chk("esc1_irq", 32'(irq), 1);
        chk("esc1_state", 32'(state), 32'(ST_WARN));
        chk("esc1_tmo", 32'(tmo_count), 1);
        repeat (99) tick();
        chk("esc_wait_state", 32'(state), 32'(ST_WARN));
        wdtov = 1'b1;
        tick();
        wdtov = 1'b0;
        chk("esc2_state", 32'(state), 32'(ST_RESET));
        chk("esc2_sysrst", 32'(sys_rst_req), 1);
        chk("esc2_tmo", 32'(tmo_count), 2);
        pulse_cnt = 1;

        // Kicks during RESET must be ignored.
        kick_valid = 1'b1;
        kick_data  = KEY;
        tick();
        if (sys_rst_req) pulse_cnt++;
        kick_data = 32'h0;
        tick();
        if (sys_rst_req) pulse_cnt++;
        chk("rstkick_reload", 32'(reload_req), 0);
        kick_valid = 1'b0;
        tick();
        if (sys_rst_req) pulse_cnt++;
        chk("rstkick_reload2", 32'(reload_req), 0);
        chk("rstkick_badkey", 32'(bad_key), 0);
        chk("rstkick_state", 32'(state), 32'(ST_RESET));
        for (int k = 0; k < 40 && sys_rst_req; k++) begin
            tick();
            if (sys_rst_req) pulse_cnt++;
        end
        chk("esc_pulse_len", 32'(pulse_cnt), 16);
        chk("esc_exit_state", 32'(state), 32'(ST_ARMED));
        chk("esc_exit_tmo", 32'(tmo_count), 2);
        chk("esc_exit_irq", 32'(irq), 1);

        // Service from WARN.
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("clr_irq", 32'(irq), 0);
        wdtov = 1'b1;
        tick();
        wdtov = 1'b0;
        chk("svc_warn", 32'(state), 32'(ST_WARN));
        chk("svc_tmo", 32'(tmo_count), 3);
        kick_valid = 1'b1;
        kick_data  = KEY;
        tick();
        kick_valid = 1'b0;
        chk("svc_reload", 32'(reload_req), 1);
        chk("svc_state", 32'(state), 32'(ST_ARMED));
        tick();
        chk("svc_reload_end", 32'(reload_req), 0);
        chk("svc_irq_held", 32'(irq), 1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("svc_irq_clr", 32'(irq), 0);

        // Bad key with simultaneous clear: set wins.
        kick_valid = 1'b1;
        kick_data  = 32'h0;
        irq_clr    = 1'b1;
        tick();
        kick_valid = 1'b0;
        irq_clr    = 1'b0;
        chk("bad_badkey", 32'(bad_key), 1);
        chk("bad_irq", 32'(irq), 1);
        chk("bad_state", 32'(state), 32'(ST_ARMED));
        chk("bad_reload", 32'(reload_req), 0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        chk("bad_clr_key", 32'(bad_key), 0);
        chk("bad_clr_irq", 32'(irq), 0);

        // Valid kick coincident with an overflow edge: kick wins.
        wdtov      = 1'b1;
        kick_valid = 1'b1;
        kick_data  = KEY;
        tick();
        wdtov      = 1'b0;
        kick_valid = 1'b0;
        chk("conf_state", 32'(state), 32'(ST_ARMED));
        chk("conf_tmo", 32'(tmo_count), 3);
        chk("conf_reload", 32'(reload_req), 1);
        chk("conf_irq", 32'(irq), 0);
        tick();

        // Disable drops to IDLE, re-enable re-arms.
        en = 1'b0;
        tick();
        chk("dis_state", 32'(state), 32'(ST_IDLE));
        en = 1'b1;
        tick();
        chk("reen_state", 32'(state), 32'(ST_ARMED));

        // 300 kick-less timeouts; count starts at 3.
        for (int i = 0; i < 300; i++) begin
            wdtov = 1'b1;
            tick();
            wdtov = 1'b0;
            tick();
            wait_reset_exit("sat_rst_exit");
            if (i == 99) chk("sat_tmo_mid", 32'(tmo_count), 103);
        end
        chk("sat_tmo", 32'(tmo_count), 255);
        chk("sat_state", 32'(state), 32'(ST_ARMED));

        // Mid-pulse asynchronous reset.
        wdtov = 1'b1;
        tick();
        wdtov = 1'b0;
        tick();
        wdtov = 1'b1;
        tick();
        wdtov = 1'b0;
        repeat (3) tick();
        chk("mid_sysrst_hi", 32'(sys_rst_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_sysrst", 32'(sys_rst_req), 0);
        chk("mid_state", 32'(state), 32'(ST_IDLE));
        chk("mid_tmo", 32'(tmo_count), 0);
        chk("mid_irq", 32'(irq), 0);
        #10;
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
